lap_recorder: RTL and testbench

//  Lap-time controller for the stopwatch. Captures the live 16-bit BCD time into a

---
 rtl/lap_recorder.sv | 163 ++++++++++++++++
 tb/tb_lap_recorder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lap_recorder.sv
// ============================================================================
// Module   : lap_recorder
// Purpose  : Stopwatch lap buffer and recall sequencer. Optional feature
//            macro LAP_OVERWRITE_EN: a lap while full replaces the oldest lap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lap_recorder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             running,
    input  logic [WIDTH-1:0] time_in,
    input  logic             lap_button,
    input  logic             recall_button,
    input  logic             clear,
    output logic [WIDTH-1:0] show,
    output logic             recalling,
    output logic [AW:0]      lap_count,
    output logic             full,
    output logic             overflow
);

    typedef enum logic [0:0] {
        ST_LIVE   = 1'b0,
        ST_RECALL = 1'b1
    } state_t;

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];

    state_t           r_state;
    state_t           w_state_n;
    logic [AW-1:0]    r_rd_idx;
    logic [AW-1:0]    w_rd_idx_n;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    w_wr_ptr_n;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    w_head_n;
    logic [AW:0]      r_lap_count;
    logic [AW:0]      w_lap_count_n;
    logic             r_full;
    logic             r_overflow;
    logic             w_overflow_n;
    logic             r_lap_q;
    logic             r_rec_q;
    logic [WIDTH-1:0] r_show;

    logic             w_lap_press;
    logic             w_rec_press;
    logic             w_we;
    logic [AW:0]      w_last_idx;
    logic [AW-1:0]    w_rd_addr;

    assign w_lap_press = lap_button & ~r_lap_q;
    assign w_rec_press = recall_button & ~r_rec_q;
    assign w_last_idx  = r_lap_count - c_cnt_one;
    assign w_rd_addr   = r_head + r_rd_idx;

    // Next-state and buffer bookkeeping; the recall decision sees the count
    // from before any write in the same cycle.
    always_comb begin
        w_state_n     = r_state;
        w_rd_idx_n    = r_rd_idx;
        w_wr_ptr_n    = r_wr_ptr;
        w_head_n      = r_head;
        w_lap_count_n = r_lap_count;
        w_overflow_n  = r_overflow;
        w_we          = 1'b0;

        if (clear) begin
            w_state_n     = ST_LIVE;
            w_rd_idx_n    = '0;
            w_wr_ptr_n    = '0;
            w_head_n      = '0;
            w_lap_count_n = '0;
            w_overflow_n  = 1'b0;
        end else begin
            if (w_lap_press && running) begin
                if (!r_full) begin
                    w_we          = 1'b1;
                    w_wr_ptr_n    = r_wr_ptr + c_ptr_one;
                    w_lap_count_n = r_lap_count + c_cnt_one;
                end else begin
                    w_overflow_n = 1'b1;
`ifdef LAP_OVERWRITE_EN
                    w_we       = 1'b1;
                    w_wr_ptr_n = r_wr_ptr + c_ptr_one;
                    w_head_n   = r_head + c_ptr_one;
`endif
                end
            end

            case (r_state)
                ST_LIVE: begin
                    if (w_rec_press && (r_lap_count != '0)) begin
                        w_state_n  = ST_RECALL;
                        w_rd_idx_n = '0;
                    end
                end
                ST_RECALL: begin
                    if (w_rec_press) begin
                        if ({1'b0, r_rd_idx} == w_last_idx) begin
                            w_state_n = ST_LIVE;
                        end else begin
                            w_rd_idx_n = r_rd_idx + c_ptr_one;
                        end
                    end
                end
                default: w_state_n = ST_LIVE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_LIVE;
            r_rd_idx    <= '0;
            r_wr_ptr    <= '0;
            r_head      <= '0;
            r_lap_count <= '0;
            r_full      <= 1'b0;
            r_overflow  <= 1'b0;
            r_lap_q     <= 1'b0;
            r_rec_q     <= 1'b0;
            r_show      <= '0;
        end else begin
            r_state     <= w_state_n;
            r_rd_idx    <= w_rd_idx_n;
            r_wr_ptr    <= w_wr_ptr_n;
            r_head      <= w_head_n;
            r_lap_count <= w_lap_count_n;
            r_full      <= (w_lap_count_n == c_depth);
            r_overflow  <= w_overflow_n;
            r_lap_q     <= lap_button;
            r_rec_q     <= recall_button;
            // Display follows the state as it stood before this edge.
            r_show      <= (r_state == ST_RECALL) ? r_mem[w_rd_addr] : time_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_we) begin
            r_mem[r_wr_ptr] <= time_in;
        end
    end

    assign show      = r_show;
    assign recalling = (r_state == ST_RECALL);
    assign lap_count = r_lap_count;
    assign full      = r_full;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_lap_recorder.sv
// ============================================================================
// Module   : tb_lap_recorder
// Purpose  : Directed and random stimulus for lap_recorder against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lap_recorder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             running;
    logic [WIDTH-1:0] time_in;
    logic             lap_button;
    logic             recall_button;
    logic             clear;
    logic [WIDTH-1:0] show;
    logic             recalling;
    logic [AW:0]      lap_count;
    logic             full;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: laps held oldest-first in a queue.
    logic [WIDTH-1:0] m_laps[$];
    bit               m_rec;
    int               m_idx;
    bit               m_ovf;
    bit               m_lap_q;
    bit               m_rec_q;
    logic [WIDTH-1:0] m_show;

    lap_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .running       (running),
        .time_in       (time_in),
        .lap_button    (lap_button),
        .recall_button (recall_button),
        .clear         (clear),
        .show          (show),
        .recalling     (recalling),
        .lap_count     (lap_count),
        .full          (full),
        .overflow      (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit clr, input bit run,
                              input bit lap, input bit rec, input logic [WIDTH-1:0] t);
        bit lp;
        bit rp;
        int n0;
        if (rst) begin
            m_laps.delete();
            m_rec   = 1'b0;
            m_idx   = 0;
            m_ovf   = 1'b0;
            m_lap_q = 1'b0;
            m_rec_q = 1'b0;
            m_show  = '0;
            return;
        end
        m_show  = m_rec ? m_laps[m_idx] : t;
        lp      = lap && !m_lap_q;
        rp      = rec && !m_rec_q;
        m_lap_q = lap;
        m_rec_q = rec;
        if (clr) begin
            m_laps.delete();
            m_rec = 1'b0;
            m_idx = 0;
            m_ovf = 1'b0;
            return;
        end
        n0 = m_laps.size();
        if (lp && run) begin
            if (n0 < DEPTH) begin
                m_laps.push_back(t);
            end else begin
                m_ovf = 1'b1;
`ifdef LAP_OVERWRITE_EN
                m_laps.push_back(t);
                void'(m_laps.pop_front());
`endif
            end
        end
        if (rp) begin
            if (!m_rec) begin
                if (n0 > 0) begin
                    m_rec = 1'b1;
                    m_idx = 0;
                end
            end else if (m_idx == n0 - 1) begin
                m_rec = 1'b0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic step(input bit rst, input bit clr, input bit run,
                        input bit lap, input bit rec, input logic [WIDTH-1:0] t);
        reset         = rst;
        clear         = clr;
        running       = run;
        lap_button    = lap;
        recall_button = rec;
        time_in       = t;
        @(posedge clock);
        model_edge(rst, clr, run, lap, rec, t);
        #1;
        check("show",      32'(show),      32'(m_show));
        check("recalling", 32'(recalling), 32'(m_rec));
        check("lap_count", 32'(lap_count), 32'(m_laps.size()));
        check("full",      32'(full),      32'(m_laps.size() == DEPTH));
        check("overflow",  32'(overflow),  32'(m_ovf));
    endtask

    // Press and release one button pair, one clock each.
    task automatic tap(input bit lap, input bit rec, input logic [WIDTH-1:0] t);
        step(1'b0, 1'b0, 1'b1, lap, rec, t);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; running = 1'b0;
        lap_button = 1'b0; recall_button = 1'b0; time_in = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2222);
        check("rst_show",  32'(show), 32'h0);
        check("rst_count", 32'(lap_count), 32'h0);

        // Single lap, recall it, leave recall
        tap(1'b1, 1'b0, 16'h0123);
        check("t1_count", 32'(lap_count), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0200);
        check("t1_rec_on", 32'(recalling), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0201);
        check("t1_show", 32'(show), 32'h0123);
        tap(1'b0, 1'b1, 16'h0300);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0301);
        check("t1_live_show", 32'(show), 32'h0301);

        // Fill to DEPTH, one extra, walk the whole recall sequence
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 1; i <= 9; i++) tap(1'b1, 1'b0, 16'(i));
        check("t2_full", 32'(full), 32'h1);
        check("t2_ovf",  32'(overflow), 32'h1);
        for (int i = 0; i < 9; i++) begin
            tap(1'b0, 1'b1, 16'h0777);
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0778);
        end

        // Lap ignored while stopped
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0500);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0500);
        check("t3_count", 32'(lap_count), 32'h0);

        // Clear wins over a same-cycle lap while recalling
        for (int i = 0; i < 3; i++) tap(1'b1, 1'b0, 16'(16'h0a00 + i));
        tap(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0bbb);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0bbc);
        check("t4_count", 32'(lap_count), 32'h0);
        tap(1'b0, 1'b1, 16'h0bbd);
        check("t4_rec", 32'(recalling), 32'h0);

        // Lap and recall together from empty
        tap(1'b1, 1'b1, 16'h0c0c);
        check("t5_count", 32'(lap_count), 32'h1);
        check("t5_rec",   32'(recalling), 32'h0);

        // Held lap button, then reset mid-hold
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'(16'h0d00 + i));
        check("t6_one", 32'(lap_count), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0e00);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0e01);
        check("t6_rst", 32'(lap_count), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0e02);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0e03);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
